// File: rtl/simd_dmem_if.sv
// Processor-side bus of the SIMD data-memory engine: a scalar load/store port
// and a vector request/done port.
interface simd_dmem_if #(
    parameter int LANE_W = 16,
    parameter int LANES  = 16,
    parameter int ADDR_W = 32
);
    logic                      s_en;
    logic                      s_we;
    logic                      s_sext;
    logic [ADDR_W-1:0]         s_addr;
    logic [LANE_W-1:0]         s_wdata;
    logic [31:0]               s_rdata;

    logic                      v_req;
    logic                      v_we;
    logic [ADDR_W-1:0]         v_addr;
    logic [LANES*LANE_W-1:0]   v_wdata;
    logic [LANES-1:0]          v_mask;
    logic                      v_ready;
    logic                      v_done;
    logic [LANES*LANE_W-1:0]   v_rdata;

    modport master (
        output s_en, s_we, s_sext, s_addr, s_wdata,
        output v_req, v_we, v_addr, v_wdata, v_mask,
        input  s_rdata, v_ready, v_done, v_rdata
    );

    modport slave (
        input  s_en, s_we, s_sext, s_addr, s_wdata,
        input  v_req, v_we, v_addr, v_wdata, v_mask,
        output s_rdata, v_ready, v_done, v_rdata
    );
endinterface

// File: rtl/simd_dmem_engine.sv
// Data memory with a single-cycle scalar port and a masked, multi-beat vector
// load/store engine sharing one element array.
module simd_dmem_engine #(
    parameter int LANE_W     = 16,
    parameter int LANES      = 16,
    parameter int PORT_LANES = 4,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = 32
) (
    input  logic       clk,
    input  logic       reset,
    simd_dmem_if.slave bus
);
    localparam int SHIFT  = $clog2(LANE_W / 8);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LSB_W  = $clog2(LANES);
    localparam int BEATS  = LANES / PORT_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VEC_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [BEAT_W-1:0]   beat_r;
    logic                we_r;
    logic [IDX_W-1:0]    base_r;
    logic [VEC_W-1:0]    wdata_r;
    logic [LANES-1:0]    mask_r;
    logic [VEC_W-1:0]    stage_r;
    logic [VEC_W-1:0]    v_rdata_r;
    logic [31:0]         s_rdata_r;
    logic [LANE_W-1:0]   mem_r [DEPTH];

    logic [IDX_W-1:0]    s_idx_s;
    logic [IDX_W-1:0]    v_base_s;
    logic                accept_s;
    logic                last_beat_s;
    logic [LSB_W-1:0]    lane_sel_s [PORT_LANES];
    logic [IDX_W-1:0]    lane_idx_s [PORT_LANES];

    // Byte address to element index, wrapping modulo DEPTH.
    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr >> SHIFT) % ADDR_W'(DEPTH));
    endfunction

    function automatic logic [31:0] extend(input logic [LANE_W-1:0] d, input logic sext);
        return sext ? 32'($signed(d)) : 32'(d);
    endfunction

    assign s_idx_s     = to_index(bus.s_addr);
    assign v_base_s    = to_index(bus.v_addr) & ~IDX_W'(LANES - 1);
    assign accept_s    = (state_r == IDLE) && bus.v_req;
    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

    assign bus.v_ready = (state_r == IDLE) && !reset;
    assign bus.v_done  = (state_r == DONE);
    assign bus.v_rdata = v_rdata_r;
    assign bus.s_rdata = s_rdata_r;

    // Lanes and element indices touched by the current beat.
    always_comb begin
        for (int p = 0; p < PORT_LANES; p++) begin
            lane_sel_s[p] = LSB_W'(int'(beat_r) * PORT_LANES + p);
            lane_idx_s[p] = base_r | IDX_W'(lane_sel_s[p]);
        end
    end

    // Next-state logic of the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = BURST;
                else          state_s = IDLE;
            end
            BURST: begin
                if (last_beat_s) state_s = DONE;
                else             state_s = BURST;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, request latch, beat counter and registered read outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            beat_r    <= '0;
            we_r      <= 1'b0;
            base_r    <= '0;
            wdata_r   <= '0;
            mask_r    <= '0;
            v_rdata_r <= '0;
            s_rdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                we_r    <= bus.v_we;
                base_r  <= v_base_s;
                wdata_r <= bus.v_wdata;
                mask_r  <= bus.v_mask;
                beat_r  <= '0;
            end else if (state_r == BURST) begin
                beat_r <= beat_r + BEAT_W'(1);
            end
            if (state_r == DONE && !we_r) begin
                v_rdata_r <= stage_r;
            end
            if (bus.s_en && !bus.s_we) begin
                s_rdata_r <= extend(mem_r[s_idx_s], bus.s_sext);
            end
        end
    end

    // Element array and load staging; the vector write is issued last so it
    // overrides a scalar write to the same element, and reads see old data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (bus.s_en && bus.s_we) begin
                mem_r[s_idx_s] <= bus.s_wdata;
            end
            if (state_r == BURST) begin
                for (int p = 0; p < PORT_LANES; p++) begin
                    if (we_r && mask_r[lane_sel_s[p]]) begin
                        mem_r[lane_idx_s[p]] <= wdata_r[lane_sel_s[p]*LANE_W +: LANE_W];
                    end
                    if (!we_r) begin
                        stage_r[lane_sel_s[p]*LANE_W +: LANE_W] <= mem_r[lane_idx_s[p]];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_simd_dmem_engine.sv
// Randomised and directed bench for simd_dmem_engine, checked every cycle
// against a timeline model of the memory and the vector operation.
module tb_simd_dmem_engine;
    localparam int LW    = 16;
    localparam int NL    = 16;
    localparam int PL    = 4;
    localparam int DP    = 4096;
    localparam int BEATS = NL / PL;
    localparam int VW    = NL * LW;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    simd_dmem_if #(.LANE_W(LW), .LANES(NL), .ADDR_W(32)) bus ();

    simd_dmem_engine #(
        .LANE_W(LW), .LANES(NL), .PORT_LANES(PL), .DEPTH(DP), .ADDR_W(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [LW-1:0]  m_mem   [DP];
    logic [LW-1:0]  m_stage [NL];
    bit             m_busy;
    int             m_age;
    bit             m_we;
    int             m_base;
    logic [VW-1:0]  m_wdata;
    logic [NL-1:0]  m_mask;
    logic [31:0]    m_s_rdata;
    logic [VW-1:0]  m_v_rdata;

    function automatic int sidx(input logic [31:0] a);
        return int'((a >> 1) % 32'(DP));
    endfunction

    function automatic int vbase(input logic [31:0] a);
        return sidx(a) & ~(NL - 1);
    endfunction

    function automatic logic [31:0] mext(input logic [LW-1:0] d, input bit sext);
        return sext ? {{16{d[15]}}, d} : {16'h0000, d};
    endfunction

    function automatic logic [LW-1:0] pat(input int idx);
        return 16'(idx * 37 + 32'h1234);
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: age counts cycles since acceptance; beats are ages 1..BEATS, done is BEATS+1.
    always @(posedge clk) begin
        int s_i;
        if (reset) begin
            m_busy    = 1'b0;
            m_age     = 0;
            m_s_rdata = 32'd0;
            m_v_rdata = '0;
        end else begin
            s_i = sidx(bus.s_addr);
            if (bus.s_en && !bus.s_we) m_s_rdata = mext(m_mem[s_i], bus.s_sext);
            if (m_busy && m_age >= 1 && m_age <= BEATS && !m_we)
                for (int l = (m_age - 1) * PL; l < m_age * PL; l++) m_stage[l] = m_mem[m_base + l];
            if (m_busy && m_age == BEATS + 1 && !m_we)
                for (int l = 0; l < NL; l++) m_v_rdata[l*LW +: LW] = m_stage[l];
            if (bus.s_en && bus.s_we) m_mem[s_i] = bus.s_wdata;
            if (m_busy && m_age >= 1 && m_age <= BEATS && m_we)
                for (int l = (m_age - 1) * PL; l < m_age * PL; l++)
                    if (m_mask[l]) m_mem[m_base + l] = m_wdata[l*LW +: LW];
            if (m_busy) begin
                if (m_age == BEATS + 1) m_busy = 1'b0;
                else                    m_age++;
            end else if (bus.v_req) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_we    = bus.v_we;
                m_base  = vbase(bus.v_addr);
                m_wdata = bus.v_wdata;
                m_mask  = bus.v_mask;
            end
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(posedge clk) begin
        #1;
        check("v_ready", bus.v_ready, !m_busy && !reset);
        check("v_done",  bus.v_done,  m_busy && m_age == BEATS + 1);
        check("s_rdata", bus.s_rdata, m_s_rdata);
        check("v_rdata", bus.v_rdata, m_v_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic start_vec(input bit we, input logic [31:0] a,
                             input logic [VW-1:0] d, input logic [NL-1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.v_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.v_ready, 1'b1);
        bus.v_req = 1'b1; bus.v_we = we; bus.v_addr = a; bus.v_wdata = d; bus.v_mask = m;
        @(negedge clk);
        bus.v_req = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.v_done && lat < 50);
        check("done_seen", bus.v_done, 1'b1);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return 32'h400 + 32'($urandom_range(0, 63));
    endfunction

    initial begin
        int            lat;
        int            d1;
        int            d2;
        logic [VW-1:0] vec;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.s_en = 1'b0; bus.s_we = 1'b0; bus.s_sext = 1'b0; bus.s_addr = 32'd0; bus.s_wdata = 16'd0;
        bus.v_req = 1'b0; bus.v_we = 1'b0; bus.v_addr = 32'd0; bus.v_wdata = '0; bus.v_mask = '0;
        repeat (3) @(negedge clk);
        check("reset_s_rdata", bus.s_rdata, 32'd0);
        check("reset_v_ready", bus.v_ready, 1'b0);
        reset = 1'b0;

        // Known contents everywhere before any read.
        for (int i = 0; i < DP; i++) begin
            bus.s_en = 1'b1; bus.s_we = 1'b1; bus.s_addr = 32'(i * 2); bus.s_wdata = pat(i);
            @(negedge clk);
        end
        bus.s_en = 1'b0; bus.s_we = 1'b0;

        // Scalar extension.
        bus.s_en = 1'b1; bus.s_we = 1'b1; bus.s_addr = 32'h10; bus.s_wdata = 16'h8001;
        @(negedge clk);
        bus.s_we = 1'b0; bus.s_sext = 1'b1;
        @(posedge clk); #1;
        check("sext_read", bus.s_rdata, 32'hFFFF8001);
        @(negedge clk);
        bus.s_sext = 1'b0;
        @(posedge clk); #1;
        check("zext_read", bus.s_rdata, 32'h00008001);
        @(negedge clk);
        bus.s_en = 1'b0;

        // Vector store then load.
        for (int i = 0; i < NL; i++) vec[i*LW +: LW] = 16'(32'h100 + i);
        start_vec(1'b1, 32'h40, vec, 16'hFFFF);
        wait_done(lat);
        check("store_done_lat", lat, 4);
        start_vec(1'b0, 32'h40, '0, '0);
        wait_done(lat);
        check("load_done_lat", lat, 4);
        check("ready_in_done", bus.v_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_done", bus.v_ready, 1'b1);
        check("vector_load", bus.v_rdata, vec);

        // Masked store.
        start_vec(1'b1, 32'h80, '0, 16'hFFFF);
        wait_done(lat);
        for (int i = 0; i < NL; i++) vec[i*LW +: LW] = 16'hAAAA;
        start_vec(1'b1, 32'h80, vec, 16'h00F0);
        wait_done(lat);
        start_vec(1'b0, 32'h80, '0, '0);
        wait_done(lat);
        @(posedge clk); #1;
        for (int i = 0; i < NL; i++) vec[i*LW +: LW] = (i >= 4 && i <= 7) ? 16'hAAAA : 16'h0000;
        check("masked_store", bus.v_rdata, vec);

        // Collision: vector beat and scalar write to element base+5 in the same cycle.
        vec = '0; vec[5*LW +: LW] = 16'h1111;
        start_vec(1'b1, 32'hC0, vec, 16'h0020);
        @(negedge clk);
        bus.s_en = 1'b1; bus.s_we = 1'b1; bus.s_addr = 32'hCA; bus.s_wdata = 16'h2222;
        @(negedge clk);
        bus.s_en = 1'b0; bus.s_we = 1'b0;
        wait_done(lat);
        @(negedge clk);
        bus.s_en = 1'b1; bus.s_sext = 1'b0; bus.s_addr = 32'hCA;
        @(posedge clk); #1;
        check("collision_vec_wins", bus.s_rdata, 32'h00001111);
        @(negedge clk);
        bus.s_en = 1'b0;
        vec[5*LW +: LW] = 16'h3333;
        start_vec(1'b1, 32'hC0, vec, 16'h0020);
        @(negedge clk);
        bus.s_en = 1'b1; bus.s_addr = 32'hCA;
        @(posedge clk); #1;
        check("read_during_write_old", bus.s_rdata, 32'h00001111);
        @(negedge clk);
        bus.s_en = 1'b0;
        wait_done(lat);

        // Reset during beat 2 of a full-mask store.
        for (int i = 0; i < NL; i++) vec[i*LW +: LW] = 16'(32'h5000 + i);
        start_vec(1'b1, 32'h200, vec, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_in_reset", bus.v_ready, 1'b0);
        check("v_rdata_reset", bus.v_rdata, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", bus.v_ready, 1'b1);
        d1 = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.v_done) d1++;
        end
        check("no_done_after_reset", d1, 0);
        start_vec(1'b0, 32'h200, '0, '0);
        wait_done(lat);
        @(posedge clk); #1;
        for (int i = 8; i < NL; i++) vec[i*LW +: LW] = pat(32'h100 + i);
        check("reset_partial_store", bus.v_rdata, vec);

        // Wrap and handshake: v_req held high on element DEPTH-LANES+3 (plus one DEPTH).
        @(negedge clk);
        bus.v_req = 1'b1; bus.v_we = 1'b0; bus.v_addr = 32'd8166 + 32'd8192;
        d1 = 0; d2 = 0;
        for (int p = 1; p <= 12; p++) begin
            @(posedge clk); #1;
            if (bus.v_done) begin
                if (d1 == 0)      d1 = p;
                else if (d2 == 0) d2 = p;
            end
        end
        check("held_req_first_done", d1, 5);
        check("held_req_second_done", d2, 11);
        for (int i = 0; i < NL; i++) vec[i*LW +: LW] = pat(DP - NL + i);
        check("wrap_load", bus.v_rdata, vec);
        @(negedge clk);
        bus.v_req = 1'b0;

        // Randomised traffic, biased to a small window for collisions.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 299) == 0);
            bus.s_en     = 1'($urandom_range(0, 1));
            bus.s_we     = 1'($urandom_range(0, 1));
            bus.s_sext   = 1'($urandom_range(0, 1));
            bus.s_addr   = rnd_addr();
            bus.s_wdata  = 16'($urandom());
            bus.v_req    = ($urandom_range(0, 3) == 0);
            bus.v_we     = 1'($urandom_range(0, 1));
            bus.v_addr   = rnd_addr();
            for (int w = 0; w < VW / 32; w++) bus.v_wdata[w*32 +: 32] = $urandom();
            bus.v_mask   = 16'($urandom());
        end
        @(negedge clk);
        reset = 1'b0; bus.s_en = 1'b0; bus.v_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
